// File: rtl/fpu_issue_scheduler_pkg.sv
// Shared core-pipeline types for FP issue: slow-unit FSM states, fast-pipe entry, default latency.
// Pure declarations; no timing or flow-control behaviour of its own.
package fpu_issue_scheduler_pkg;

    localparam int FAST_LAT_DEFAULT = 3;

    typedef enum logic [1:0] {
        SLOW_IDLE,
        SLOW_BUSY,
        SLOW_HOLD
    } slow_state_e;

    typedef struct packed {
        logic       vld;
        logic       wr;
        logic [4:0] rd;
    } fast_entry_t;

endpackage

// File: rtl/fpu_scoreboard.sv
// Per-register pending mask for the FP file; reads reflect registered state only.
// Set and clear take effect at the next edge; set beats clear on the same register.
module fpu_scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en_i,
    input  logic [4:0] set_idx_i,
    input  logic       clr_en_i,
    input  logic [4:0] clr_idx_i,
    input  logic [4:0] rs1_idx_i,
    input  logic [4:0] rs2_idx_i,
    input  logic [4:0] rs3_idx_i,
    input  logic [4:0] rd_idx_i,
    output logic       rs1_pend_o,
    output logic       rs2_pend_o,
    output logic       rs3_pend_o,
    output logic       rd_pend_o
);

    logic [31:0] pend_q;
    logic [31:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
        if (set_en_i) pend_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign rs1_pend_o = pend_q[rs1_idx_i];
    assign rs2_pend_o = pend_q[rs2_idx_i];
    assign rs3_pend_o = pend_q[rs3_idx_i];
    assign rd_pend_o  = pend_q[rd_idx_i];

endmodule

// File: rtl/fpu_issue_scheduler.sv
// Issues FP ops to a fixed-latency fast pipe and a single-op slow unit, sharing one FP write port.
// Fast results write back FAST_LAT cycles after accept; slow results yield the port to the fast pipe.
module fpu_issue_scheduler
    import fpu_issue_scheduler_pkg::*;
#(
    parameter int FAST_LAT = FAST_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_valid,
    input  logic        fast_fpu_dispatch,
    input  logic        slow_fpu_dispatch,
    input  logic        fpu_reg_write,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rs3,
    input  logic        uses_rs3,
    output logic        disp_stall,
    output logic        slow_start,
    input  logic        slow_done,
    input  logic [31:0] slow_result,
    output logic        fp_wb_en,
    output logic [4:0]  fp_wb_rd,
    output logic        fp_wb_sel,
    output logic [31:0] fp_wb_slow_data
);

    slow_state_e state_q, state_d;
    logic        slow_wr_q, slow_wr_d;
    logic [4:0]  slow_rd_q, slow_rd_d;
    logic [31:0] buf_q, buf_d;
    fast_entry_t fast_q [FAST_LAT];
    fast_entry_t fast_new;
    fast_entry_t fast_exit;

    logic rs1_p, rs2_p, rs3_p, rd_p;
    logic any_req, hazard, accept, slow_acc, fast_wb, slow_wb;
    logic [31:0] slow_wb_data;

    fpu_scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (accept & fpu_reg_write),
        .set_idx_i  (rd),
        .clr_en_i   (fp_wb_en),
        .clr_idx_i  (fp_wb_rd),
        .rs1_idx_i  (rs1),
        .rs2_idx_i  (rs2),
        .rs3_idx_i  (rs3),
        .rd_idx_i   (rd),
        .rs1_pend_o (rs1_p),
        .rs2_pend_o (rs2_p),
        .rs3_pend_o (rs3_p),
        .rd_pend_o  (rd_p)
    );

    // Hazards come only from registered state, so a result writing back this cycle still stalls.
    assign any_req  = disp_valid & (fast_fpu_dispatch | slow_fpu_dispatch);
    assign hazard   = rs1_p | rs2_p | (uses_rs3 & rs3_p) | (fpu_reg_write & rd_p)
                    | (slow_fpu_dispatch & (state_q != SLOW_IDLE));
    assign disp_stall = any_req & hazard;
    assign accept     = any_req & ~hazard;
    assign slow_acc   = accept & slow_fpu_dispatch;

    assign fast_new.vld = accept & fast_fpu_dispatch & ~slow_fpu_dispatch;
    assign fast_new.wr  = fpu_reg_write;
    assign fast_new.rd  = rd;
    assign fast_exit    = fast_q[FAST_LAT-1];
    assign fast_wb      = fast_exit.vld & fast_exit.wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FAST_LAT; i++) fast_q[i] <= '0;
        end else begin
            fast_q[0] <= fast_new;
            for (int i = 1; i < FAST_LAT; i++) fast_q[i] <= fast_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        slow_rd_d    = slow_rd_q;
        slow_wr_d    = slow_wr_q;
        buf_d        = buf_q;
        slow_start   = 1'b0;
        slow_wb      = 1'b0;
        slow_wb_data = '0;
        case (state_q)
            SLOW_IDLE: begin
                if (slow_acc) begin
                    slow_start = 1'b1;
                    slow_rd_d  = rd;
                    slow_wr_d  = fpu_reg_write;
                    state_d    = SLOW_BUSY;
                end
            end
            SLOW_BUSY: begin
                if (slow_done) begin
                    if (!slow_wr_q) begin
                        state_d = SLOW_IDLE;
                    end else if (fast_wb) begin
                        buf_d   = slow_result;
                        state_d = SLOW_HOLD;
                    end else begin
                        slow_wb      = 1'b1;
                        slow_wb_data = slow_result;
                        state_d      = SLOW_IDLE;
                    end
                end
            end
            SLOW_HOLD: begin
                if (!fast_wb) begin
                    slow_wb      = 1'b1;
                    slow_wb_data = buf_q;
                    state_d      = SLOW_IDLE;
                end
            end
            default: state_d = SLOW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SLOW_IDLE;
            slow_rd_q <= '0;
            slow_wr_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            slow_rd_q <= slow_rd_d;
            slow_wr_q <= slow_wr_d;
            buf_q     <= buf_d;
        end
    end

    assign fp_wb_en        = fast_wb | slow_wb;
    assign fp_wb_sel       = slow_wb & ~fast_wb;
    assign fp_wb_rd        = fast_wb ? fast_exit.rd : (slow_wb ? slow_rd_q : 5'd0);
    assign fp_wb_slow_data = slow_wb_data;

endmodule

// File: tb/tb_fpu_issue_scheduler.sv
// Directed bench: stimulus pushes expected writebacks; a negedge monitor pops and compares them.
module tb_fpu_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_valid, fast_fpu_dispatch, slow_fpu_dispatch, fpu_reg_write, uses_rs3;
    logic [4:0]  rd, rs1, rs2, rs3;
    logic        disp_stall, slow_start, slow_done;
    logic [31:0] slow_result;
    logic        fp_wb_en, fp_wb_sel;
    logic [4:0]  fp_wb_rd;
    logic [31:0] fp_wb_slow_data;

    typedef struct {
        logic [4:0]  rd;
        logic        sel;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  passed    = 0;
    int  total     = 0;
    int  start_cnt = 0;

    always #5 clk = ~clk;

    fpu_issue_scheduler #(.FAST_LAT(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .disp_valid        (disp_valid),
        .fast_fpu_dispatch (fast_fpu_dispatch),
        .slow_fpu_dispatch (slow_fpu_dispatch),
        .fpu_reg_write     (fpu_reg_write),
        .rd                (rd),
        .rs1               (rs1),
        .rs2               (rs2),
        .rs3               (rs3),
        .uses_rs3          (uses_rs3),
        .disp_stall        (disp_stall),
        .slow_start        (slow_start),
        .slow_done         (slow_done),
        .slow_result       (slow_result),
        .fp_wb_en          (fp_wb_en),
        .fp_wb_rd          (fp_wb_rd),
        .fp_wb_sel         (fp_wb_sel),
        .fp_wb_slow_data   (fp_wb_slow_data)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        disp_valid = 0; fast_fpu_dispatch = 0; slow_fpu_dispatch = 0; fpu_reg_write = 0;
        rd = 0; rs1 = 0; rs2 = 0; rs3 = 0; uses_rs3 = 0; slow_done = 0;
    endtask

    task automatic op(input logic f, input logic s, input logic w,
                      input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
        disp_valid = 1; fast_fpu_dispatch = f; slow_fpu_dispatch = s; fpu_reg_write = w;
        rd = d; rs1 = a; rs2 = b; rs3 = 0; uses_rs3 = 0;
    endtask

    task automatic push(input logic [4:0] d, input logic s, input logic [31:0] x);
        wb_t e;
        e.rd = d; e.sel = s; e.data = x;
        exp_q.push_back(e);
    endtask

    task automatic done(input logic [31:0] x);
        slow_done   = 1;
        slow_result = x;
    endtask

    // Writeback monitor
    always @(negedge clk) begin
        if (slow_start === 1'b1) start_cnt++;
        if (fp_wb_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL wb_unexpected: got en=%0b rd=%0d sel=%0b, required no writeback",
                         fp_wb_en, fp_wb_rd, fp_wb_sel);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_rd", 32'(fp_wb_rd), 32'(e.rd));
                chk("wb_sel", 32'(fp_wb_sel), 32'(e.sel));
                if (e.sel) chk("wb_data", fp_wb_slow_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int n;
        int sc0;
        idle;
        slow_result = '0;

        // Reset, with an op presented that must be dropped
        step; step;
        op(1, 0, 1, 5'd11, 5'd0, 5'd0);
        @(negedge clk);
        chk("rst_wb_en", 32'(fp_wb_en), 0);
        chk("rst_slow_start", 32'(slow_start), 0);
        chk("rst_wb_rd", 32'(fp_wb_rd), 0);
        chk("rst_wb_sel", 32'(fp_wb_sel), 0);
        chk("rst_wb_data", fp_wb_slow_data, 0);
        step;
        rst = 0;
        idle;
        @(negedge clk);
        chk("rst_mask", dut.u_sb.pend_q, 0);
        step;

        // RAW on f3 through the fast pipe
        op(1, 0, 1, 5'd3, 5'd1, 5'd2);
        push(5'd3, 0, 0);
        @(negedge clk);
        chk("raw_first_stall", 32'(disp_stall), 0);
        step;
        op(1, 0, 1, 5'd4, 5'd3, 5'd0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!disp_stall) break;
            n++;
            step;
        end
        chk("raw_stall_cycles", 32'(n), 3);
        push(5'd4, 0, 0);
        step;
        idle;
        repeat (4) step;

        // Slow occupancy: fdiv f5 then fsqrt f6
        sc0 = start_cnt;
        op(0, 1, 1, 5'd5, 5'd1, 5'd2);
        @(negedge clk);
        chk("occ_div_stall", 32'(disp_stall), 0);
        chk("occ_div_start", 32'(slow_start), 1);
        step;
        op(0, 1, 1, 5'd6, 5'd7, 5'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("occ_busy_stall", 32'(disp_stall), 1);
            chk("occ_busy_start", 32'(slow_start), 0);
            step;
        end
        done(32'h4040_0000);
        push(5'd5, 1, 32'h4040_0000);
        @(negedge clk);
        chk("occ_done_stall", 32'(disp_stall), 1);
        step;
        slow_done = 0;
        @(negedge clk);
        chk("occ_sqrt_stall", 32'(disp_stall), 0);
        chk("occ_sqrt_start", 32'(slow_start), 1);
        step;
        idle;
        step;
        done(32'h3fb5_04f3);
        push(5'd6, 1, 32'h3fb5_04f3);
        step;
        idle;
        step;
        chk("occ_start_count", 32'(start_cnt - sc0), 2);

        // Port collision: slow_done meets a fast f1 exit
        op(0, 1, 1, 5'd5, 5'd1, 5'd2);
        @(negedge clk);
        chk("coll_div_start", 32'(slow_start), 1);
        step;
        op(1, 0, 1, 5'd1, 5'd2, 5'd3);
        push(5'd1, 0, 0);
        @(negedge clk);
        chk("coll_fast_stall", 32'(disp_stall), 0);
        step;
        idle;
        step;
        step;
        done(32'hC0A0_0000);
        push(5'd5, 1, 32'hC0A0_0000);
        @(negedge clk);
        chk("coll_first_sel", 32'(fp_wb_sel), 0);
        chk("coll_first_rd", 32'(fp_wb_rd), 1);
        step;
        slow_done = 0;
        slow_result = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("coll_second_sel", 32'(fp_wb_sel), 1);
        step;
        idle;
        step;

        // WAW on f2: slow in flight, fast wants the same destination
        op(0, 1, 1, 5'd2, 5'd1, 5'd3);
        step;
        op(1, 0, 1, 5'd2, 5'd1, 5'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("waw_stall", 32'(disp_stall), 1);
            step;
        end
        done(32'h4120_0000);
        push(5'd2, 1, 32'h4120_0000);
        @(negedge clk);
        chk("waw_stall_at_wb", 32'(disp_stall), 1);
        step;
        slow_done = 0;
        @(negedge clk);
        chk("waw_release", 32'(disp_stall), 0);
        push(5'd2, 0, 0);
        step;
        idle;
        repeat (4) step;

        // Reset while the slow unit is busy
        op(0, 1, 1, 5'd7, 5'd1, 5'd2);
        step;
        idle;
        step;
        rst = 1;
        step;
        rst = 0;
        done(32'h1234_5678);
        @(negedge clk);
        chk("rstb_no_wb", 32'(fp_wb_en), 0);
        chk("rstb_mask", dut.u_sb.pend_q, 0);
        step;
        slow_done = 0;
        op(0, 1, 1, 5'd8, 5'd7, 5'd0);
        @(negedge clk);
        chk("rstb_new_stall", 32'(disp_stall), 0);
        chk("rstb_new_start", 32'(slow_start), 1);
        step;
        idle;
        step;
        done(32'h0BAD_F00D);
        push(5'd8, 1, 32'h0BAD_F00D);
        step;
        idle;
        step;

        // Integer destination (feq) leaves no pending bit and no writeback
        op(1, 0, 0, 5'd9, 5'd1, 5'd2);
        @(negedge clk);
        chk("int_stall", 32'(disp_stall), 0);
        step;
        op(1, 0, 1, 5'd10, 5'd9, 5'd0);
        @(negedge clk);
        chk("int_consumer_stall", 32'(disp_stall), 0);
        chk("int_no_pend", 32'(dut.u_sb.pend_q[9]), 0);
        push(5'd10, 0, 0);
        step;
        op(1, 0, 1, 5'd11, 5'd10, 5'd0);
        disp_valid = 0;
        @(negedge clk);
        chk("novalid_stall", 32'(disp_stall), 0);
        step;
        disp_valid = 1;
        fast_fpu_dispatch = 0;
        @(negedge clk);
        chk("nodispatch_stall", 32'(disp_stall), 0);
        step;
        idle;
        repeat (6) step;

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fpu_issue_scheduler.md
FPU_ISSUE_SCHEDULER -- requirements
Module: fpu_issue_scheduler

Interface
REQ-001 SHALL have parameter FAST_LAT, default 3, range 1..8: fixed fast-FPU latency in cycles from dispatch to result.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL have ports: disp_valid in 1; fast_fpu_dispatch in 1; slow_fpu_dispatch in 1; fpu_reg_write in 1; rd in 5; rs1, rs2, rs3 in 5 each; uses_rs3 in 1. These are the decode-stage FP op and its control bits.
REQ-004 SHALL have port disp_stall out 1: hold decode; the op is not accepted this cycle.
REQ-005 SHALL have port slow_start out 1: single-cycle start pulse to the slow unit (fdiv/fsqrt/fmadd family).
REQ-006 SHALL have ports: slow_done in 1, single-cycle completion pulse; slow_result in 32, valid with slow_done.
REQ-007 SHALL have ports: fp_wb_en out 1; fp_wb_rd out 5; fp_wb_sel out 1 (0 = fast pipe data, 1 = slow data); fp_wb_slow_data out 32. Together these drive the single FP register-file write port.

Function
REQ-008 SHALL accept an op when disp_valid=1 and disp_stall=0; accept = (fast_fpu_dispatch | slow_fpu_dispatch) & disp_valid & ~disp_stall.
REQ-009 SHALL keep a 32-bit pending mask, one bit per FP register; f0 is an ordinary register.
REQ-010 SHALL assert disp_stall combinationally, from registered state only (no same-cycle bypass), when any of the following is pending: rs1; rs2; rs3 with uses_rs3=1; or rd with fpu_reg_write=1.
REQ-011 SHALL also assert disp_stall when slow_fpu_dispatch=1 and the slow FSM is not IDLE.
REQ-012 SHALL keep disp_stall=0 when disp_valid=0 or when neither dispatch bit is set.
REQ-013 SHALL, on accepting an op with fpu_reg_write=1, set pending[rd] at the next edge.
REQ-014 SHALL track fast ops in a FAST_LAT-deep shift register of {valid, wr, rd}. An entry exiting with valid&wr writes back that cycle: fp_wb_en=1, fp_wb_sel=0, fp_wb_rd=entry rd.
REQ-015 SHALL have slow FSM states IDLE, BUSY, HOLD. It holds slow_rd and slow_wr registers and a 32-bit result buffer.
REQ-016 SHALL assert slow_start in the accept cycle of a slow op, and move IDLE->BUSY, latching rd and fpu_reg_write.
REQ-017 SHALL, in BUSY on slow_done: if no fast writeback that cycle and slow_wr=1, write back slow_result the same cycle (fp_wb_sel=1) and go to IDLE. If a fast writeback occurs that cycle, buffer slow_result and go to HOLD.
REQ-018 SHALL treat slow_done with slow_wr=0 (integer-destination op) as an immediate return to IDLE with no FP writeback.
REQ-019 SHALL, in HOLD, write back the buffer on the first cycle with no fast writeback, then go to IDLE. The fast pipe always has port priority.
REQ-020 SHALL clear pending[fp_wb_rd] at the edge after any cycle with fp_wb_en=1. If a set and a clear target the same register in one cycle, set wins.
REQ-021 SHALL ignore slow_done outside BUSY.
REQ-022 SHALL drive fp_wb_slow_data = slow_result in the BUSY writeback cycle, and the buffer in HOLD; value is don't-care otherwise.
REQ-023 SHALL keep all outputs other than disp_stall free of combinational paths from slow_done to slow_start.

Reset
REQ-024 SHALL, on rst, clear the pending mask and the shift register, set the FSM to IDLE, and clear the buffer; rst overrides any same-cycle accept.
REQ-025 SHALL drive slow_start=0, fp_wb_en=0, fp_wb_sel=0, fp_wb_rd=0 and fp_wb_slow_data=0 during and after reset until a new event occurs.
REQ-026 SHALL make a reset asserted mid-slow-op abandon that op; a slow_done arriving afterwards is ignored per REQ-021.

Structure
REQ-027 SHALL place the slow FSM state enum and the FAST_LAT default in the shared core pipeline package.
REQ-028 SHALL implement the pending mask as one sub-module, fpu_scoreboard: set/clear ports plus three read ports and one rd read port.

Verification
REQ-029 SHALL cover the RAW case: fast fadd rd=f3, then fsub rs1=f3 next cycle -> stall for FAST_LAT cycles, accept in the cycle after f3 writes back.
REQ-030 SHALL cover slow occupancy: fdiv rd=f5 accepted, then fsqrt rd=f6 -> stall until the fdiv writeback, with slow_start pulsing exactly once per op.
REQ-031 SHALL cover port collision: slow_done arrives in the same cycle a fast entry exits with rd=f1 -> f1 is written first (sel=0), slow rd=f5 is written the next free cycle (sel=1), with data equal to the slow_result captured at done.
REQ-032 SHALL cover WAW: fdiv rd=f2 in flight, then fadd rd=f2 -> stall until the slow writeback clears pending[2].
REQ-033 SHALL cover reset in BUSY: rst pulse, then slow_done -> no writeback, mask = 0, and a new slow op is accepted immediately.
REQ-034 SHALL cover integer destination: feq (fast, fpu_reg_write=0) -> no pending bit set and fp_wb_en stays 0.
